// File: rtl/mips_pkg.sv
// Shared MIPS fetch-path types: branch kind encoding, fetch FSM states and reset PC.
package mips_pkg;

  typedef enum logic [1:0] {
    BR_COND = 2'b00,
    BR_JUMP = 2'b01,
    BR_JREG = 2'b10,
    BR_RSVD = 2'b11
  } br_kind_t;

  typedef enum logic [1:0] {
    F_EMPTY = 2'd0,
    F_WAIT  = 2'd1,
    F_FULL  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  // Word-aligned, sign-extended conditional-branch displacement.
  function automatic logic signed [31:0] br_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/br_target_gen.sv
// Combinational redirect decision and target address for the branch/jump sitting in ID.
module br_target_gen
  import mips_pkg::*;
(
  input  logic        br_valid_i,
  input  br_kind_t    br_kind_i,
  input  logic        cmp_result_i,
  input  logic        ready_i,
  input  logic [31:0] pc_i,
  input  logic [15:0] imm16_i,
  input  logic [25:0] index26_i,
  input  logic [31:0] rs_data_i,
  output logic        taken_o,
  output logic [31:0] target_o
);

  logic signed [31:0] br_off;
  logic        [31:0] pc_plus4;
  logic               kind_taken;

  always_comb begin
    br_off     = br_offset(imm16_i);
    pc_plus4   = pc_i + 32'd4;
    kind_taken = 1'b0;
    target_o   = pc_plus4;
    case (br_kind_i)
      BR_COND: begin
        kind_taken = cmp_result_i;
        target_o   = pc_plus4 + $unsigned(br_off);
      end
      BR_JUMP: begin
        kind_taken = 1'b1;
        target_o   = {pc_i[31:28], index26_i, 2'b00};
      end
      BR_JREG: begin
        kind_taken = 1'b1;
        target_o   = rs_data_i;
      end
      default: kind_taken = 1'b0;
    endcase
    // A stalled ID stage has not really accepted the branch yet.
    taken_o = kind_taken & br_valid_i & ready_i;
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// IF-stage PC controller: one-entry fetch buffer over a req/ack instruction memory,
// with branch redirects that always let the single in-flight delay slot complete.
module fetch_pc_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_br_valid,
  input  logic [1:0]  id_br_kind,
  input  logic        cmp_result,
  input  logic [31:0] id_pc,
  input  logic [15:0] id_imm16,
  input  logic [25:0] id_index26,
  input  logic [31:0] id_rs_data,
  input  logic        id_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        redirect
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic         pend_valid_q, pend_valid_d;
  logic [31:0]  pend_target_q, pend_target_d;
  logic         redirect_q;

  logic         taken;
  logic [31:0]  target;
  logic         issue;
  logic         in_wait;
  logic         ack_acc;
  logic [31:0]  fetch_addr;
  logic [31:0]  cur_addr;

  br_target_gen u_br_target_gen (
    .br_valid_i   (id_br_valid),
    .br_kind_i    (br_kind_t'(id_br_kind)),
    .cmp_result_i (cmp_result),
    .ready_i      (id_ready),
    .pc_i         (id_pc),
    .imm16_i      (id_imm16),
    .index26_i    (id_index26),
    .rs_data_i    (id_rs_data),
    .taken_o      (taken),
    .target_o     (target)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= F_EMPTY;
      pc_q          <= RESET_PC;
      req_addr_q    <= '0;
      if_pc_q       <= '0;
      if_instr_q    <= '0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      redirect_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_addr_q    <= req_addr_d;
      if_pc_q       <= if_pc_d;
      if_instr_q    <= if_instr_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      redirect_q    <= taken;
    end
  end

  // A consumed FULL buffer issues exactly like EMPTY, so streaming has no bubble.
  always_comb begin
    in_wait    = (state_q == F_WAIT);
    issue      = (state_q == F_EMPTY) || ((state_q == F_FULL) && id_ready);
    fetch_addr = taken ? target : (pend_valid_q ? pend_target_q : pc_q);
    cur_addr   = issue ? fetch_addr : req_addr_q;
    ack_acc    = (issue || in_wait) && imem_ack;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      F_EMPTY: state_d = ack_acc ? F_FULL : F_WAIT;
      F_WAIT:  if (ack_acc) state_d = F_FULL;
      F_FULL:  if (id_ready) state_d = ack_acc ? F_FULL : F_WAIT;
      default: state_d = F_EMPTY;
    endcase
  end

  always_comb begin
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    if_pc_d       = if_pc_q;
    if_instr_d    = if_instr_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    if (issue) begin
      req_addr_d   = fetch_addr;
      pend_valid_d = 1'b0;
    end
    if (ack_acc) begin
      if_pc_d      = cur_addr;
      if_instr_d   = imem_rdata;
      pend_valid_d = 1'b0;
      // In WAIT the returning word is the delay slot, so a redirect lands in pc;
      // on an issue cycle the redirect already steered the request itself.
      if (in_wait && taken)
        pc_d = target;
      else if (in_wait && pend_valid_q)
        pc_d = pend_target_q;
      else
        pc_d = cur_addr + 32'd4;
    end else if (in_wait) begin
      if (taken) begin
        pend_valid_d  = 1'b1;
        pend_target_d = target;
      end
    end else if (taken) begin
      pc_d = target;
    end
  end

  always_comb begin
    imem_req  = reset && (issue || in_wait);
    imem_addr = cur_addr;
    if_valid  = (state_q == F_FULL);
    if_pc     = if_pc_q;
    if_instr  = if_instr_q;
    redirect  = redirect_q;
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-level model of the fetch stream.
module tb_fetch_pc_ctrl;

  logic        clk;
  logic        reset;
  logic        id_br_valid;
  logic [1:0]  id_br_kind;
  logic        cmp_result;
  logic [31:0] id_pc;
  logic [15:0] id_imm16;
  logic [25:0] id_index26;
  logic [31:0] id_rs_data;
  logic        id_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        redirect;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory model controls
  int   fixed_lat = 0;
  bit   rand_mode = 0;
  bit   spur      = 0;
  int   cnt;
  int   lat_cur;

  // Reference model state
  bit          m_buf_v, m_out, m_redir, m_pend;
  logic [31:0] m_buf_pc, m_buf_instr, m_out_addr, m_next;
  bit          c_tk, c_consume, c_issue, c_req, c_ack;
  logic [31:0] c_tgt, c_addr;

  fetch_pc_ctrl #(.RESET_PC(32'h0000_3000)) dut (
    .clk        (clk),
    .reset      (reset),
    .id_br_valid(id_br_valid),
    .id_br_kind (id_br_kind),
    .cmp_result (cmp_result),
    .id_pc      (id_pc),
    .id_imm16   (id_imm16),
    .id_index26 (id_index26),
    .id_rs_data (id_rs_data),
    .id_ready   (id_ready),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_instr   (if_instr),
    .redirect   (redirect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: acks after lat_cur waiting cycles; may toggle ack while idle.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= 0;
      lat_cur <= fixed_lat;
    end else if (imem_req && !imem_ack) begin
      cnt <= cnt + 1;
    end else begin
      cnt <= 0;
      if (imem_req && imem_ack)
        lat_cur <= rand_mode ? int'($urandom_range(0, 3)) : fixed_lat;
    end
  end

  assign imem_ack   = imem_req ? (cnt >= lat_cur) : spur;
  assign imem_rdata = imem_addr ^ 32'h5A5A_C3C3;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_target(input logic [1:0] kind, input logic [31:0] pc,
                                               input logic [15:0] imm, input logic [25:0] idx,
                                               input logic [31:0] rs);
    logic [31:0] sx;
    sx = {{16{imm[15]}}, imm};
    case (kind)
      2'b00:   return pc + 32'd4 + (sx << 2);
      2'b01:   return {pc[31:28], idx, 2'b00};
      2'b10:   return rs;
      default: return pc + 32'd4;
    endcase
  endfunction

  // Per-cycle comparison against the model; model then advances with this cycle's inputs.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!reset) begin
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_redirect", 32'(redirect), 32'd0);
        m_buf_v = 0; m_out = 0; m_redir = 0; m_pend = 0;
        m_buf_pc = '0; m_buf_instr = '0; m_out_addr = '0;
        m_next = 32'h0000_3000;
      end else begin
        c_tk = id_br_valid && id_ready &&
               (id_br_kind == 2'b01 || id_br_kind == 2'b10 || (id_br_kind == 2'b00 && cmp_result));
        c_tgt     = model_target(id_br_kind, id_pc, id_imm16, id_index26, id_rs_data);
        c_consume = m_buf_v && id_ready;
        c_issue   = !m_out && (!m_buf_v || c_consume);
        c_req     = m_out || c_issue;
        c_addr    = m_out ? m_out_addr : (c_tk ? c_tgt : m_next);
        chk("m_imem_req", 32'(imem_req), 32'(c_req));
        if (c_req) chk("m_imem_addr", imem_addr, c_addr);
        chk("m_if_valid", 32'(if_valid), 32'(m_buf_v));
        if (m_buf_v) begin
          chk("m_if_pc", if_pc, m_buf_pc);
          chk("m_if_instr", if_instr, m_buf_instr);
        end
        chk("m_redirect", 32'(redirect), 32'(m_redir));
        if (c_tk && m_pend) begin
          n_fail++;
          $display("FAIL taken_while_pending: got taken=1, expected 0 (t=%0t)", $time);
        end
        c_ack   = c_req && imem_ack;
        m_redir = c_tk;
        if (c_issue) m_next = c_addr + 32'd4;
        else if (c_tk) m_next = c_tgt;
        if (c_ack) begin
          m_buf_v = 1; m_buf_pc = c_addr; m_buf_instr = imem_rdata;
          m_out = 0; m_pend = 0;
        end else begin
          if (c_consume) m_buf_v = 0;
          if (c_issue) begin
            m_out = 1; m_out_addr = c_addr; m_pend = 0;
          end else if (m_out && c_tk) begin
            m_pend = 1;
          end
        end
      end
    end
  end

  task automatic idle_id();
    id_br_valid = 0; id_br_kind = 2'b00; cmp_result = 0;
    id_pc = '0; id_imm16 = '0; id_index26 = '0; id_rs_data = '0;
    id_ready = 1; spur = 0;
  endtask

  // Returns positioned in the first cycle after reset release (at the negedge).
  task automatic do_reset(input int lat);
    @(negedge clk);
    fixed_lat = lat;
    idle_id();
    reset = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1;
  endtask

  // Returns 3 time units into the cycle whose buffer holds pc.
  task automatic wait_buf(input logic [31:0] pc, input string nm);
    bit ok;
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      #3;
      if (if_valid === 1'b1 && if_pc === pc) ok = 1;
      else @(negedge clk);
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: buffer never held %h, last if_pc %h", nm, pc, if_pc);
    end
  endtask

  initial begin
    logic [31:0] save_instr, save_pc;
    reset = 0;
    idle_id();
    @(negedge clk);
    #3;
    chk("reset_req", 32'(imem_req), 32'd0);
    chk("reset_if_valid", 32'(if_valid), 32'd0);
    chk("reset_if_pc", if_pc, 32'd0);
    chk("reset_if_instr", if_instr, 32'd0);
    chk("reset_redirect", 32'(redirect), 32'd0);

    // Zero-latency stream
    do_reset(0);
    #3;
    chk("stream_req0", 32'(imem_req), 32'd1);
    chk("stream_addr0", imem_addr, 32'h3000);
    chk("stream_valid0", 32'(if_valid), 32'd0);
    @(negedge clk); #3;
    chk("stream_addr1", imem_addr, 32'h3004);
    chk("stream_pc1", if_pc, 32'h3000);
    chk("stream_instr1", if_instr, 32'h3000 ^ 32'h5A5A_C3C3);
    @(negedge clk); #3;
    chk("stream_addr2", imem_addr, 32'h3008);
    chk("stream_pc2", if_pc, 32'h3004);
    @(negedge clk); #3;
    chk("stream_pc3", if_pc, 32'h3008);
    chk("stream_valid3", 32'(if_valid), 32'd1);

    // beq taken with delay slot still delivered
    do_reset(0);
    @(negedge clk);
    @(negedge clk);
    id_br_valid = 1; id_br_kind = 2'b00; cmp_result = 1; id_pc = 32'h3000; id_imm16 = 16'h0003;
    #3;
    chk("beq_slot_pc", if_pc, 32'h3004);
    chk("beq_slot_valid", 32'(if_valid), 32'd1);
    chk("beq_fetch", imem_addr, 32'h3010);
    @(negedge clk); idle_id(); #3;
    chk("beq_redirect", 32'(redirect), 32'd1);
    chk("beq_target_pc", if_pc, 32'h3010);
    chk("beq_next", imem_addr, 32'h3014);
    @(negedge clk); #3;
    chk("beq_redirect_once", 32'(redirect), 32'd0);

    // jr accepted mid-WAIT with latency 3
    do_reset(3);
    wait_buf(32'h3000, "jr_first");
    chk("jr_slot_req", imem_addr, 32'h3004);
    @(negedge clk);
    id_br_valid = 1; id_br_kind = 2'b10; id_pc = 32'h3000; id_rs_data = 32'h0000_4000;
    #3;
    chk("jr_hold_addr", imem_addr, 32'h3004);
    @(negedge clk); idle_id(); #3;
    chk("jr_redirect", 32'(redirect), 32'd1);
    @(negedge clk);
    wait_buf(32'h3004, "jr_slot");
    chk("jr_target", imem_addr, 32'h0000_4000);
    chk("jr_target_req", 32'(imem_req), 32'd1);

    // j in the same cycle as the ack (latency 1)
    do_reset(1);
    #3;
    chk("j_first_addr", imem_addr, 32'h3000);
    @(negedge clk);
    id_br_valid = 1; id_br_kind = 2'b01; id_pc = 32'h0000_2FFC; id_index26 = 26'h0000100;
    #3;
    chk("j_ack_now", 32'(imem_ack), 32'd1);
    @(negedge clk); idle_id(); #3;
    chk("j_slot_pc", if_pc, 32'h3000);
    chk("j_target", imem_addr, 32'h0000_0400);
    chk("j_redirect", 32'(redirect), 32'd1);
    @(negedge clk);
    wait_buf(32'h0000_0400, "j_target_buf");

    // Stall in FULL, stray acks must be ignored
    do_reset(0);
    @(negedge clk);
    @(negedge clk);
    id_ready = 0; spur = 1;
    #3;
    save_instr = if_instr;
    save_pc    = if_pc;
    chk("stall_pc", save_pc, 32'h3004);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(negedge clk); spur = (i % 2 == 0); #3; end
      chk("stall_req", 32'(imem_req), 32'd0);
      chk("stall_instr", if_instr, save_instr);
      chk("stall_valid", 32'(if_valid), 32'd1);
    end
    @(negedge clk); id_ready = 1; spur = 0; #3;
    chk("stall_resume_req", 32'(imem_req), 32'd1);
    chk("stall_resume_addr", imem_addr, save_pc + 32'd4);

    // Reset while a redirect is pending
    do_reset(3);
    wait_buf(32'h3000, "rmid_first");
    @(negedge clk);
    id_br_valid = 1; id_br_kind = 2'b10; id_pc = 32'h3000; id_rs_data = 32'h0000_5000;
    @(negedge clk); idle_id(); reset = 0; #3;
    chk("rmid_req", 32'(imem_req), 32'd0);
    chk("rmid_valid", 32'(if_valid), 32'd0);
    chk("rmid_if_pc", if_pc, 32'd0);
    chk("rmid_if_instr", if_instr, 32'd0);
    chk("rmid_redirect", 32'(redirect), 32'd0);
    @(negedge clk); reset = 1; #3;
    chk("rmid_first_addr", imem_addr, 32'h3000);
    chk("rmid_first_req", 32'(imem_req), 32'd1);

    // Randomized traffic
    rand_mode = 1;
    do_reset(0);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 499) == 0) begin
        idle_id();
        reset = 0;
        @(negedge clk);
        reset = 1;
      end
      id_ready    = ($urandom_range(0, 3) != 0);
      id_br_valid = ($urandom_range(0, 2) == 0) && !m_pend;
      id_br_kind  = 2'($urandom_range(0, 3));
      cmp_result  = 1'($urandom_range(0, 1));
      id_pc       = $urandom & 32'hFFFF_FFFC;
      id_imm16    = 16'($urandom);
      id_index26  = 26'($urandom);
      id_rs_data  = $urandom;
      spur        = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    idle_id();
    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog timeout");
  end

endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Instruction-fetch PC controller for the 5-stage MIPS pipeline, at the consumer end of the ID-stage branch comparator. Takes the comparator's `cmp_result` plus decoded branch/jump fields from ID, computes the redirect target, and drives a variable-latency instruction-memory request/acknowledge interface. It presents fetched instructions to the IF/ID register through a one-entry buffer and keeps MIPS single-delay-slot semantics.

## Interface

**Parameters**
- `RESET_PC`, default 32'h0000_3000: first fetch address after reset.

**Ports**
- `clk`, in, 1: clock; all state on rising edge.
- `reset`, in, 1: reset; asynchronous, active-low.
- `id_br_valid`, in, 1: a branch/jump instruction occupies ID this cycle.
- `id_br_kind`, in, 2: 00 conditional branch, 01 j/jal, 10 jr/jalr, 11 reserved (treated as not taken).
- `cmp_result`, in, 1: comparator output; 1 = condition true.
- `id_pc`, in, 32: PC of the instruction in ID.
- `id_imm16`, in, 16: branch offset field.
- `id_index26`, in, 26: jump index field.
- `id_rs_data`, in, 32: forwarded rs value (jr target).
- `id_ready`, in, 1: IF/ID accepts `if_instr` this cycle (not stalled).
- `imem_req`, out, 1: fetch request; held until acknowledged.
- `imem_addr`, out, 32: fetch address; stable while `imem_req` is high and unacknowledged.
- `imem_ack`, in, 1: `imem_rdata` valid; may assert in the first cycle of a request.
- `imem_rdata`, in, 32: fetched instruction.
- `if_valid`, out, 1: buffer holds an instruction.
- `if_pc`, out, 32: address of the buffered instruction.
- `if_instr`, out, 32: buffered instruction.
- `redirect`, out, 1: one-cycle pulse when a taken branch/jump is accepted.

## Operation

- Taken condition: `taken = id_br_valid & id_ready & (kind==01 | kind==10 | (kind==00 & cmp_result))`.
- Target, with all arithmetic mod 2^32:
  - kind 00: `id_pc + 4 + (sext(id_imm16) << 2)`.
  - kind 01: `{id_pc[31:28], id_index26, 2'b00}`.
  - kind 10: `id_rs_data`, used unmodified.
- Invariant: at most one instruction is in flight, counting the buffer plus any outstanding request. When a branch is taken, that in-flight instruction is always the delay slot (`id_pc+4`).
- Registers:
  - `pc`: next address to request.
  - buffer: `if_valid`, `if_pc`, `if_instr`.
  - `pend_valid`, `pend_target`.
  - state `EMPTY` / `WAIT` / `FULL`.
- `EMPTY`: drive `imem_req=1` and `imem_addr=fetch_addr`, then move to `WAIT`. If `imem_ack` arrives in the same cycle, handle it as described for `WAIT`.
- `fetch_addr` selection:
  - if `taken` is high in the same cycle, `fetch_addr = target`;
  - otherwise `fetch_addr = pend_valid ? pend_target : pc`.
  - Either way, `pend_valid` clears.
- `WAIT`: `imem_req=1`, with the address held. On `imem_ack`:
  - buffer ← {`imem_addr`, `imem_rdata`}, `if_valid=1`;
  - `pc` ← `taken ? target : imem_addr+4`;
  - go to `FULL`.
- `taken` in `WAIT` without an ack in the same cycle: `pend_valid=1`, `pend_target=target`. The next ack then loads `pc` ← `pend_target`.
- `FULL`: `if_valid=1`.
  - If `id_ready`: the buffer is consumed, and a new request issues in the same cycle with state `EMPTY` behaviour (no bubble).
  - If not `id_ready`: hold everything, `imem_req=0`.
- `taken` while in `FULL` or `EMPTY`, i.e. no outstanding request: `pc` ← target directly; no pending entry is created.
- A `taken` that arrives while `pend_valid=1` is impossible by the invariant. The bench flags it as an assertion.
- `imem_ack` outside `WAIT` is ignored.

## Timing

- Reset values (asynchronous, on `reset=0`):
  - `pc=RESET_PC`, state `EMPTY`;
  - `if_valid=0`, `if_pc=0`, `if_instr=0`;
  - `pend_valid=0`, `pend_target=0`;
  - `redirect=0`, `imem_req=0` while in reset.
- First `imem_req` with `RESET_PC` is issued in the first cycle after reset deasserts.
- Zero-latency memory with `id_ready=1` continuously: one instruction per cycle, `if_valid` steady high.
- N-cycle ack latency: buffer loads on the ack edge, and `if_valid` rises the cycle after the ack.
- `redirect` is registered and asserted the cycle after `taken`.
- Reset mid-request drops the outstanding fetch. The memory shares the same reset.

## Structure

- Shared package `mips_pkg`: `br_kind_t` encoding (00/01/10/11), fetch state enum, and the `RESET_PC` default constant.
- One sub-module, `br_target_gen`: purely combinational, producing `target` and `taken` from the ID fields. Everything else lives in `fetch_pc_ctrl`.

## Test plan

- **Reset and stream:** release reset with ack in the same cycle as the request and `id_ready=1` → `imem_addr` 0x3000, 0x3004, 0x3008 on consecutive cycles; `if_pc` follows one cycle later.
- **beq taken, delay slot:** `id_pc`=0x3000, kind 00, `cmp_result=1`, imm16=0x0003 → 0x3004 is still delivered, next fetch is 0x3010, `redirect` pulses once.
- **Pending redirect:** ack latency 3, `jr` with `id_rs_data`=0x0000_4000 accepted mid-`WAIT` → delay slot is delivered, next `imem_addr`=0x4000.
- **Simultaneous ack and taken:** `j` with index 0x0000100 in the same cycle as the ack → next `imem_addr`=0x0000_0400, and `pend_valid` never sets.
- **Stall:** `id_ready=0` for 4 cycles in `FULL` → `imem_req=0` and `if_instr` stable; on release, fetch resumes at `if_pc+4`.
- **Reset mid-fetch:** `reset` low during `WAIT` with target pending → all outputs take reset values, and the first fetch after release is 0x3000.
